// File: rtl/alu_operand_issue.sv
// Decode/operand stage ahead of the ALU: register-file read with writeback bypass,
// immediate handling, and a one-deep valid/ready output register.
module alu_operand_issue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [1:0]        opcode,
    output logic [4:0]        Funksioni,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [2:0]        dest,
    output logic [DATA_W-1:0] store_data,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  issue_count
);

    localparam int unsigned IMM_W = 8;
    localparam logic [4:0]  FN_ADD = 5'b00100;

    localparam logic [1:0] OP_R    = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_LW   = 2'b10;
    localparam logic [1:0] OP_SW   = 2'b11;

    logic [DATA_W-1:0] regs [NREGS];

    logic [1:0]        f_op;
    logic [2:0]        f_rs;
    logic [2:0]        f_rt;
    logic [2:0]        f_rd;
    logic [4:0]        f_funct;
    logic [IMM_W-1:0]  f_imm;
    logic [DATA_W-1:0] imm_sext;

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    logic [1:0]        nxt_opcode;
    logic [4:0]        nxt_fn;
    logic [DATA_W-1:0] nxt_a;
    logic [DATA_W-1:0] nxt_b;
    logic [2:0]        nxt_dest;
    logic [DATA_W-1:0] nxt_store;

    logic accept;

    assign instr_ready = !alu_valid || alu_ready;
    assign accept      = instr_valid && instr_ready;

    assign f_op     = instr[15:14];
    assign f_rs     = instr[13:11];
    assign f_rt     = instr[10:8];
    assign f_rd     = instr[7:5];
    assign f_funct  = instr[4:0];
    assign f_imm    = instr[7:0];
    assign imm_sext = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};

    // Operand reads: r0 is hardwired zero, a same-cycle writeback wins over the array
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (f_rs != 3'd0) begin
            if (wb_en && (wb_addr == f_rs)) rs_val = wb_data;
            else                            rs_val = regs[f_rs];
        end
        if (f_rt != 3'd0) begin
            if (wb_en && (wb_addr == f_rt)) rt_val = wb_data;
            else                            rt_val = regs[f_rt];
        end
    end

    // Bundle decode; funct only matters for R-type
    always_comb begin
        nxt_opcode = f_op;
        nxt_fn     = FN_ADD;
        nxt_a      = rs_val;
        nxt_b      = imm_sext;
        nxt_dest   = f_rt;
        nxt_store  = '0;
        case (f_op)
            OP_R: begin
                nxt_fn   = f_funct;
                nxt_b    = rt_val;
                nxt_dest = f_rd;
            end
            OP_ADDI, OP_LW: begin
                nxt_dest = f_rt;
            end
            OP_SW: begin
                nxt_dest  = 3'd0;
                nxt_store = rt_val;
            end
            default: begin
                nxt_dest = f_rt;
            end
        endcase
    end

    // Register file; writeback proceeds regardless of the issue handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 3'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Output register: loads on accept, holds while stalled, drains when consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_valid   <= 1'b0;
            opcode      <= '0;
            Funksioni   <= '0;
            a           <= '0;
            b           <= '0;
            dest        <= '0;
            store_data  <= '0;
            issue_count <= '0;
        end else if (accept) begin
            alu_valid   <= 1'b1;
            opcode      <= nxt_opcode;
            Funksioni   <= nxt_fn;
            a           <= nxt_a;
            b           <= nxt_b;
            dest        <= nxt_dest;
            store_data  <= nxt_store;
            issue_count <= issue_count + CNT_W'(1);
        end else if (alu_ready) begin
            alu_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed + random bench for alu_operand_issue; predicted bundles are queued at
// accept time and compared against the held output register every cycle.
module tb_alu_operand_issue;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        alu_valid;
    logic        alu_ready;
    logic [1:0]  opcode;
    logic [4:0]  Funksioni;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic [15:0] store_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] issue_count;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  fn;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
        logic [15:0] sd;
    } bundle_t;

    bundle_t     sb_q[$];
    logic [15:0] m_regs [8];
    logic        m_valid;
    logic [15:0] m_cnt;
    int          n_vec;
    int          n_err;

    alu_operand_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .opcode      (opcode),
        .Funksioni   (Funksioni),
        .a           (a),
        .b           (b),
        .dest        (dest),
        .store_data  (store_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rdv(input logic [2:0] n);
        if (n == 3'd0)                 return 16'h0;
        if (wb_en && (wb_addr == n))   return wb_data;
        return m_regs[n];
    endfunction

    function automatic bundle_t predict(input logic [15:0] ins);
        bundle_t     e;
        logic [15:0] imm;
        imm = {{8{ins[7]}}, ins[7:0]};
        e.op = ins[15:14];
        e.a  = rdv(ins[13:11]);
        case (ins[15:14])
            2'b00:   begin e.fn = ins[4:0]; e.b = rdv(ins[10:8]); e.dest = ins[7:5];  e.sd = 16'h0; end
            2'b11:   begin e.fn = 5'b00100; e.b = imm;            e.dest = 3'd0;      e.sd = rdv(ins[10:8]); end
            default: begin e.fn = 5'b00100; e.b = imm;            e.dest = ins[10:8]; e.sd = 16'h0; end
        endcase
        return e;
    endfunction

    // Advance one clock, updating the reference model with the edge's effects, then check.
    task automatic tick();
        bit      acc;
        bit      consume;
        bit      was_reset;
        bundle_t e;
        #1;
        chk("instr_ready", 32'(instr_ready), 32'(!m_valid || alu_ready));
        was_reset = reset;
        acc       = !reset && instr_valid && (!m_valid || alu_ready);
        consume   = !reset && m_valid && alu_ready;
        e         = predict(instr);
        if (reset) begin
            sb_q.delete();
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
            m_valid = 1'b0;
            m_cnt   = 16'h0;
        end else begin
            if (consume && sb_q.size() > 0) void'(sb_q.pop_front());
            if (acc) begin
                sb_q.push_back(e);
                m_cnt = m_cnt + 16'd1;
            end
            m_valid = acc ? 1'b1 : (consume ? 1'b0 : m_valid);
            if (wb_en && wb_addr != 3'd0) m_regs[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        chk("alu_valid", 32'(alu_valid), 32'(m_valid));
        chk("issue_count", 32'(issue_count), 32'(m_cnt));
        if (was_reset) begin
            chk("rst_bundle", 32'({opcode, Funksioni, dest} | 10'(a | b | store_data)), 32'h0);
        end else if (m_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'(alu_valid), 32'h0);
            end else begin
                chk("opcode",     32'(opcode),     32'(sb_q[0].op));
                chk("Funksioni",  32'(Funksioni),  32'(sb_q[0].fn));
                chk("a",          32'(a),          32'(sb_q[0].a));
                chk("b",          32'(b),          32'(sb_q[0].b));
                chk("dest",       32'(dest),       32'(sb_q[0].dest));
                chk("store_data", 32'(store_data), 32'(sb_q[0].sd));
            end
        end
    endtask

    task automatic wb(input logic [2:0] ad, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = ad; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins);
        instr_valid = 1'b1; instr = ins;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] held_a;
        n_vec = 0; n_err = 0;
        m_valid = 1'b0; m_cnt = 16'h0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; alu_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        @(posedge clk);
        tick();
        reset = 1'b0;

        // R-type add of R1=10, R2=6
        wb(3'd1, 16'd10);
        wb(3'd2, 16'd6);
        issue(16'h0A04);
        chk("tp1_a", 32'(a), 32'd10);
        chk("tp1_b", 32'(b), 32'd6);
        chk("tp1_cnt", 32'(issue_count), 32'd1);
        tick();

        // addi with negative immediate
        wb(3'd1, 16'd32);
        issue(16'h4BF0);
        chk("addi_b", 32'(b), 32'hFFF0);
        chk("addi_dest", 32'(dest), 32'd3);

        // Same-cycle bypass on rs, then r0 write suppression
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'd99;
        issue(16'h1004);
        wb_en = 1'b0;
        chk("bypass_a", 32'(a), 32'd99);
        wb(3'd0, 16'd55);
        issue(16'h0004);
        chk("r0_a", 32'(a), 32'd0);

        // Stall for three cycles with a pending instruction
        alu_ready = 1'b0;
        instr_valid = 1'b1; instr = 16'h0A04;
        held_a = a;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_a", 32'(a), 32'(held_a));
        chk("stall_ready", 32'(instr_ready), 32'd0);
        alu_ready = 1'b1;
        instr = 16'h0A04; tick();
        instr = 16'h4BF0; tick();
        instr = 16'hCA04; tick();
        instr = 16'h8A7F; tick();
        instr_valid = 1'b0;
        tick();

        // sw carries R[rt] as store data
        wb(3'd1, 16'd10);
        wb(3'd2, 16'd20);
        issue(16'hCA04);
        chk("sw_sd", 32'(store_data), 32'd20);
        chk("sw_b", 32'(b), 32'd4);

        // Reset while a bundle is stalled, with a competing accept
        alu_ready = 1'b0;
        issue(16'h0A04);
        instr_valid = 1'b1; instr = 16'h4BF0; reset = 1'b1;
        tick();
        reset = 1'b0; instr_valid = 1'b0; alu_ready = 1'b1;
        chk("rst_cnt", 32'(issue_count), 32'd0);
        issue(16'h0804);
        chk("rst_r1", 32'(a), 32'd0);

        // Random traffic including writeback/read collisions
        for (int i = 0; i < 200; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
            alu_ready   = ($urandom_range(0, 3) != 0);
            wb_en       = 1'($urandom_range(0, 1));
            wb_addr     = 3'($urandom);
            wb_data     = 16'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
